sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares one single-port SRAM (active-low cen/wen, registered Q with 1-cycle read latency, default 8-bit data and 4-bit address) between two requesters, e.g. pixel reader and pixel writer of the image pipeline.
- Arbitrates per cycle, drives the SRAM control, address and data pins, and routes read data back with a valid strobe to the requester that issued the read.
- Sits directly between the processing FSMs and the SRAM instance.

Parameters:
- D_WIDTH, 8, SRAM data width.
- A_WIDTH, 4, SRAM address width (depth 2**A_WIDTH).
- FIXED_PRIO, 0, 0 = round-robin; 1 = requester 0 always wins.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1  access request, held until granted.
- we0, we1  in  1  1 = write, 0 = read; sampled with req.
- addr0, addr1  in  A_WIDTH  access address.
- wdata0, wdata1  in  D_WIDTH  write data.
- gnt0, gnt1  out  1  combinational; request accepted this cycle.
- rvalid0, rvalid1  out  1  read data valid for that requester.
- rdata0, rdata1  out  D_WIDTH  read data (= sram_q while own rvalid is high, else 0).
- sram_cen  out  1  SRAM chip enable, active-low.
- sram_wen  out  1  SRAM write enable, active-low (1 = read).
- sram_a  out  A_WIDTH  SRAM address.
- sram_d  out  D_WIDTH  SRAM write data.
- sram_q  in  D_WIDTH  SRAM registered read data.
- busy  out  1  a read is in flight (rd_pend).
- conflicts  out  8  saturating count of cycles where both requested.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While rst_n=0, outputs are forced combinationally to:
  - gnt0 = gnt1 = 0
  - rvalid0 = rvalid1 = 0
  - sram_cen = 1, sram_wen = 1
  - sram_a = 0, sram_d = 0
  - busy = 0, conflicts = 0
- Registers cleared by reset: rr_ptr = 0, rd_pend = 0, rd_id = 0, conflicts = 0.
- Arbitration (combinational, every cycle):
  - Exactly one request active: that requester wins.
  - Both active, FIXED_PRIO=1: requester 0 wins.
  - Both active, FIXED_PRIO=0: requester rr_ptr wins.
  - Winner k: gnt_k = 1, sram_cen = 0, sram_wen = ~we_k, sram_a = addr_k, sram_d = wdata_k.
  - No request: sram_cen = 1, sram_wen = 1, sram_a = 0, sram_d = 0.
- Round-robin pointer: on posedge with a grant, rr_ptr <= ~winner. Otherwise it holds. It is unused when FIXED_PRIO=1.
- Read latency:
  - A read granted in cycle N sets rd_pend <= 1 and rd_id <= winner at the end of cycle N.
  - In cycle N+1, rvalid_{rd_id} = 1 and rdata_{rd_id} = sram_q.
  - Total latency is 1 cycle. Back-to-back reads give rvalid every cycle; no bubbles are inserted.
- Writes produce no response. gnt is the completion; the SRAM updates at the end of the grant cycle.
- Read-after-write, same address, consecutive cycles: the read returns the new data. This holds naturally because the SRAM write lands before the next edge.
- The requester must keep req/we/addr/wdata stable until gnt. Dropping req before gnt is legal and withdraws the request.
- conflicts increments when req0 & req1 on a posedge, saturating at 255.
- Reset mid-read: rd_pend is cleared immediately, so the pending rvalid is lost. SRAM contents are untouched.
- No starvation in round-robin mode: with continuous contention, grants alternate 0,1,0,1. In FIXED_PRIO mode, requester 1 can starve by design.

Decomposition:
- Package sram_arb_pkg holds:
  - default widths;
  - requester-id type (1 bit);
  - localparams WR = 1'b1, RD = 1'b0;
  - CONFLICT_MAX = 8'hFF.
- One natural sub-module: rr_arb2, a 2-way round-robin/fixed-priority grant generator. Inputs: req vector, ptr, mode. Output: one-hot grant.
- The mux, read-return pipe and counter stay in the top module.

Test Plan:
- Reset with req0=1 held → gnt0=0, sram_cen=1. After rst_n rises → gnt0=1 in the same cycle, sram_a=addr0.
- Requester 0 writes 8'hA5 to addr 3; next cycle requester 0 reads addr 3 → rvalid0=1 with rdata0=8'hA5 one cycle after the read grant; rvalid1 stays 0.
- Both request reads continuously from reset, FIXED_PRIO=0 → grant order 0,1,0,1. rvalid alternates rvalid0, rvalid1 one cycle later. conflicts counts up by 1 per cycle.
- FIXED_PRIO=1, both request for 5 cycles → gnt0 every cycle, gnt1 never. When req0 drops, gnt1 in that same cycle.
- Read granted, then rst_n pulsed low before the next edge → no rvalid appears, busy=0, rr_ptr=0. A subsequent read of the same address returns the stored value.
- 300 cycles of continuous contention → conflicts saturates at 255 and stays there.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-requester SRAM arbiter.
package sram_arb_pkg;

  // Default SRAM geometry
  localparam int D_WIDTH_DEF = 8;
  localparam int A_WIDTH_DEF = 4;

  // Requester identifier: 0 or 1
  typedef logic req_id_t;

  // Value of a requester's we input for each access kind
  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

  // Contention counter saturates here
  localparam logic [7:0] CONFLICT_MAX = 8'hFF;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way grant generator: round-robin on contention, or fixed priority
// to requester 0 when mode is set. Output grant is one-hot or zero.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       mode,
  output logic [1:0] gnt
);

  // Single request wins outright; contention resolved by mode/ptr
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = (mode || !ptr) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM (active-low cen/wen, registered Q) between
// two requesters. Per-cycle arbitration drives the SRAM pins directly;
// read data returns one cycle after the grant to the requester that
// issued the read, qualified by its rvalid strobe.
//
// Handshake: a requester holds req/we/addr/wdata stable until gnt is seen
// high in the same cycle; gnt high at a rising edge means the access is
// taken. Writes complete with gnt; reads complete with rvalid exactly one
// cycle later. Dropping req before gnt withdraws the request.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int D_WIDTH    = D_WIDTH_DEF,
  parameter int A_WIDTH    = A_WIDTH_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic               req1,
  input  logic               we0,
  input  logic               we1,
  input  logic [A_WIDTH-1:0] addr0,
  input  logic [A_WIDTH-1:0] addr1,
  input  logic [D_WIDTH-1:0] wdata0,
  input  logic [D_WIDTH-1:0] wdata1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               rvalid0,
  output logic               rvalid1,
  output logic [D_WIDTH-1:0] rdata0,
  output logic [D_WIDTH-1:0] rdata1,
  output logic               sram_cen,
  output logic               sram_wen,
  output logic [A_WIDTH-1:0] sram_a,
  output logic [D_WIDTH-1:0] sram_d,
  input  logic [D_WIDTH-1:0] sram_q,
  output logic               busy,
  output logic [7:0]         conflicts
);

  logic [1:0] req_v;
  logic [1:0] gnt_v;
  logic       any_gnt;
  req_id_t    winner;
  logic       win_we;
  logic       rd_grant;

  logic       rr_ptr;
  logic       rd_pend;
  req_id_t    rd_id;
  logic [7:0] conflict_cnt;

  // Requests are masked while in reset so no grant or SRAM access leaks out
  assign req_v = rst_n ? {req1, req0} : 2'b00;

  rr_arb2 u_arb (
    .req  (req_v),
    .ptr  (rr_ptr),
    .mode (FIXED_PRIO != 0),
    .gnt  (gnt_v)
  );

  assign gnt0    = gnt_v[0];
  assign gnt1    = gnt_v[1];
  assign any_gnt = |gnt_v;
  assign winner  = gnt_v[1];

  // SRAM pin mux: winner's access, or an idle (deselected, zeroed) bus
  always_comb begin
    sram_cen = 1'b1;
    sram_wen = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    win_we   = RD;
    if (any_gnt) begin
      win_we   = winner ? we1 : we0;
      sram_cen = 1'b0;
      sram_wen = ~win_we;
      sram_a   = winner ? addr1 : addr0;
      sram_d   = winner ? wdata1 : wdata0;
    end
  end

  assign rd_grant = any_gnt && (win_we == RD);

  // Arbitration state: fairness pointer, read-return tag, contention count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= 1'b0;
      rd_pend      <= 1'b0;
      rd_id        <= 1'b0;
      conflict_cnt <= 8'h00;
    end else begin
      if (any_gnt) begin
        rr_ptr <= ~winner;
      end
      rd_pend <= rd_grant;
      if (rd_grant) begin
        rd_id <= winner;
      end
      if ((req_v == 2'b11) && (conflict_cnt != CONFLICT_MAX)) begin
        conflict_cnt <= conflict_cnt + 8'd1;
      end
    end
  end

  // Read return: registered SRAM Q routed to the tagged requester only
  assign rvalid0   = rd_pend && (rd_id == 1'b0);
  assign rvalid1   = rd_pend && (rd_id == 1'b1);
  assign rdata0    = rvalid0 ? sram_q : '0;
  assign rdata1    = rvalid1 ? sram_q : '0;
  assign busy      = rd_pend;
  assign conflicts = conflict_cnt;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: one round-robin and one fixed-priority instance
// share the same requester stimulus, each with its own behavioural SRAM.
// A transaction-level reference model predicts every output per cycle.
module tb_sram_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- shared requester inputs ----------------
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  // round-robin instance signals
  logic          g0_r, g1_r, rv0_r, rv1_r, cen_r, wen_r, busy_r;
  logic [DW-1:0] rd0_r, rd1_r, sd_r, q_r;
  logic [AW-1:0] sa_r;
  logic [7:0]    conf_r;
  // fixed-priority instance signals
  logic          g0_f, g1_f, rv0_f, rv1_f, cen_f, wen_f, busy_f;
  logic [DW-1:0] rd0_f, rd1_f, sd_f, q_f;
  logic [AW-1:0] sa_f;
  logic [7:0]    conf_f;

  sram_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(g0_r), .gnt1(g1_r), .rvalid0(rv0_r), .rvalid1(rv1_r),
    .rdata0(rd0_r), .rdata1(rd1_r),
    .sram_cen(cen_r), .sram_wen(wen_r), .sram_a(sa_r), .sram_d(sd_r),
    .sram_q(q_r), .busy(busy_r), .conflicts(conf_r)
  );

  sram_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(g0_f), .gnt1(g1_f), .rvalid0(rv0_f), .rvalid1(rv1_f),
    .rdata0(rd0_f), .rdata1(rd1_f),
    .sram_cen(cen_f), .sram_wen(wen_f), .sram_a(sa_f), .sram_d(sd_f),
    .sram_q(q_f), .busy(busy_f), .conflicts(conf_f)
  );

  // ---------------- behavioural SRAMs (registered Q) ----------------
  logic [DW-1:0] mem_r [16];
  logic [DW-1:0] mem_f [16];
  initial q_r = '0;
  initial q_f = '0;

  always @(posedge clk) begin
    if (!cen_r) begin
      if (!wen_r) mem_r[sa_r] <= sd_r;
      else        q_r <= mem_r[sa_r];
    end
  end

  always @(posedge clk) begin
    if (!cen_f) begin
      if (!wen_f) mem_f[sa_f] <= sd_f;
      else        q_f <= mem_f[sa_f];
    end
  end

  // ---------------- reference model (index 0 = rr, 1 = fixed) ----------------
  logic [DW-1:0] mm [2][16];
  bit            mptr  [2];
  bit            mpend [2];
  bit            mpid  [2];
  logic [DW-1:0] mpdat [2];
  int            mconf [2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mptr[m]  = 1'b0;
      mpend[m] = 1'b0;
      mpid[m]  = 1'b0;
      mpdat[m] = '0;
      mconf[m] = 0;
    end
  endtask

  // Who the arbiter should pick given the current requests
  function automatic bit pick(int m);
    if (req0 && req1) return (m == 1) ? 1'b0 : mptr[m];
    return req1;
  endfunction

  task automatic model_edge();
    bit any, w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      any = req0 || req1;
      w   = pick(m);
      if (req0 && req1 && mconf[m] < 255) mconf[m]++;
      mpend[m] = 1'b0;
      if (any) begin
        mptr[m] = !w;
        if (w ? we1 : we0) begin
          mm[m][w ? addr1 : addr0] = w ? wdata1 : wdata0;
        end else begin
          mpend[m] = 1'b1;
          mpid[m]  = w;
          mpdat[m] = mm[m][w ? addr1 : addr0];
        end
      end
    end
  endtask

  // ---------------- scoreboard comparison ----------------
  task automatic chk(string tag, int m, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s inst%0d: observed %0h expected %0h", tag, m, obs, exp);
    end
  endtask

  task automatic check_inst(int m, logic g0, logic g1, logic rv0, logic rv1,
                            logic cen, logic wen, logic bsy,
                            logic [DW-1:0] rd0, logic [DW-1:0] rd1,
                            logic [DW-1:0] sd, logic [AW-1:0] sa, logic [7:0] conf);
    bit any, w, e_rv0, e_rv1;
    any = rst_n && (req0 || req1);
    w   = pick(m);
    e_rv0 = mpend[m] && !mpid[m];
    e_rv1 = mpend[m] && mpid[m];
    chk("gnt0", m, g0, any && !w);
    chk("gnt1", m, g1, any && w);
    chk("sram_cen", m, cen, !any);
    chk("sram_wen", m, wen, any ? !(w ? we1 : we0) : 1'b1);
    chk("sram_a", m, sa, any ? (w ? addr1 : addr0) : '0);
    chk("sram_d", m, sd, any ? (w ? wdata1 : wdata0) : '0);
    chk("rvalid0", m, rv0, e_rv0);
    chk("rvalid1", m, rv1, e_rv1);
    chk("rdata0", m, rd0, e_rv0 ? mpdat[m] : '0);
    chk("rdata1", m, rd1, e_rv1 ? mpdat[m] : '0);
    chk("busy", m, bsy, mpend[m]);
    chk("conflicts", m, conf, mconf[m]);
  endtask

  task automatic check_all();
    check_inst(0, g0_r, g1_r, rv0_r, rv1_r, cen_r, wen_r, busy_r, rd0_r, rd1_r, sd_r, sa_r, conf_r);
    check_inst(1, g0_f, g1_f, rv0_f, rv1_f, cen_f, wen_f, busy_f, rd0_f, rd1_f, sd_f, sa_f, conf_f);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(logic r0, logic w0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                       logic r1, logic w1, logic [AW-1:0] a1, logic [DW-1:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic drive_random();
    drive(1'($urandom_range(1)), 1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom),
          1'($urandom_range(1)), 1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom));
  endtask

  task automatic drive_both_read();
    drive(1'b1, 1'b0, AW'($urandom_range(15)), DW'($urandom),
          1'b1, 1'b0, AW'($urandom_range(15)), DW'($urandom));
  endtask

  // Check mid-cycle, take the edge, update the model, return at negedge
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    @(negedge clk);

    // reset held with req0 asserted: no grant, SRAM deselected
    drive(1'b1, 1'b1, 4'd0, 8'h5A, 1'b0, 1'b0, '0, '0);
    step();
    step();
    #1;
    chk("rst_gnt0", 0, g0_r, 1'b0);
    chk("rst_cen", 1, cen_f, 1'b1);
    rst_n = 1'b1;
    #1;
    chk("post_rst_gnt0", 0, g0_r, 1'b1);
    chk("post_rst_a", 0, sa_r, 4'd0);
    step();

    // preload every address through requester 0
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, AW'(i), DW'($urandom), 1'b0, 1'b0, '0, '0);
      step();
    end

    // write A5 to 3, read it back next cycle
    drive(1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, '0, '0);
    step();
    drive(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, '0, '0);
    step();
    drive_idle();
    #1;
    chk("raw_rvalid0", 0, rv0_r, 1'b1);
    chk("raw_rdata0", 0, rd0_r, 8'hA5);
    chk("raw_rvalid1", 0, rv1_r, 1'b0);
    step();

    // continuous read contention straight out of reset
    rst_n = 1'b0;
    drive_both_read();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_both_read();
      step();
    end
    #1;
    chk("conf_after8", 0, conf_r, 8'd8);
    chk("conf_after8", 1, conf_f, 8'd8);

    // five more contended cycles, then requester 0 backs off
    for (int i = 0; i < 5; i++) begin
      drive_both_read();
      step();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd7, '0);
    #1;
    chk("fp_gnt1_on_drop", 1, g1_f, 1'b1);
    step();

    // read granted, then reset pulsed before the return edge
    drive(1'b1, 1'b0, 4'd5, '0, 1'b0, 1'b0, '0, '0);
    step();
    drive_idle();
    #1;
    chk("pend_rvalid0", 0, rv0_r, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_rvalid0", 0, rv0_r, 1'b0);
    chk("midrst_busy", 0, busy_r, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 4'd5, '0, 1'b1, 1'b0, 4'd5, '0);
    #1;
    chk("midrst_ptr_gnt0", 0, g0_r, 1'b1);
    step();
    drive_idle();
    step();

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      drive_random();
      step();
    end

    // long contention: counter saturates and holds
    for (int i = 0; i < 300; i++) begin
      drive_both_read();
      step();
    end
    #1;
    chk("conf_sat", 0, conf_r, 8'd255);
    chk("conf_sat", 1, conf_f, 8'd255);
    step();
    #1;
    chk("conf_hold", 0, conf_r, 8'd255);

    drive_idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
